// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared types for the branch resolver and condition evaluator
package branch_resolver_pkg;

    typedef enum logic [1:0] {
        BR_BCOND = 2'd0,
        BR_B     = 2'd1,
        BR_BL    = 2'd2,
        BR_RET   = 2'd3
    } br_kind_e;

    typedef enum logic [2:0] {
        ST_START      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_WAIT_FLAGS = 3'd2,
        ST_FAR        = 3'd3,
        ST_SQUASH     = 3'd4
    } br_state_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic [63:0] branch_target;
        logic [3:0]  condition;
        logic        predict_taken;
    } uop_branch;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// rtl/branch_resolver_cond_eval.sv - ARM condition code evaluation against NZCV
module cond_eval
    import branch_resolver_pkg::*;
(
    input  cond_e      cond_i,
    input  logic [3:0] nzcv_i,
    output logic       taken_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv_i;

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_EQ: taken_o = z;
            COND_NE: taken_o = !z;
            COND_CS: taken_o = c;
            COND_CC: taken_o = !c;
            COND_MI: taken_o = n;
            COND_PL: taken_o = !n;
            COND_VS: taken_o = v;
            COND_VC: taken_o = !v;
            COND_HI: taken_o = c && !z;
            COND_LS: taken_o = !(c && !z);
            COND_GE: taken_o = (n == v);
            COND_LT: taken_o = (n != v);
            COND_GT: taken_o = !z && (n == v);
            COND_LE: taken_o = !(!z && (n == v));
            COND_AL: taken_o = 1'b1;
            COND_NV: taken_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - resolves predicted branches and issues start/redirect to the front end
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter logic [63:0] START_PC      = 64'h0,
    parameter int          SQUASH_CYCLES = 4,
    parameter int          OFF_W         = 19
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             br_valid_in,
    output logic             br_ready_out,
    input  logic [1:0]       br_kind_in,
    input  logic [63:0]      br_pc_in,
    input  uop_branch        br_data_in,
    input  logic [63:0]      br_reg_val_in,
    input  logic [3:0]       nzcv_in,
    input  logic             nzcv_valid_in,
    output logic             start_signal,
    output logic             x_bcond_resolved,
    output logic             x_taken,
    output logic             x_pc_incorrect,
    output logic [63:0]      x_pc,
    output logic [OFF_W-1:0] x_correction_offset
);

    if (SQUASH_CYCLES < 1 || SQUASH_CYCLES > 15) begin : g_bad_squash
        $error("SQUASH_CYCLES must be within 1..15");
    end

    localparam logic [3:0] SQUASH_INIT = 4'(SQUASH_CYCLES);

    br_state_e        state_q, state_d;
    logic [3:0]       squash_cnt_q, squash_cnt_d;
    logic [63:0]      pc_q, reg_q, fix_pc_q;
    br_kind_e         kind_q;
    uop_branch        data_q;

    logic             start_q, start_d, resolved_q, resolved_d;
    logic             taken_q, taken_d, incorrect_q, incorrect_d;
    logic [63:0]      xpc_q, xpc_d;
    logic [OFF_W-1:0] off_q, off_d;

    logic             in_idle, accept, resolve_go, cond_taken, act_taken, mispredict, fits;
    br_kind_e         cur_kind;
    uop_branch        cur_data;
    logic [63:0]      cur_pc, cur_reg, correct_pc, delta;
    logic [63:OFF_W-1] delta_hi;

    assign in_idle      = (state_q == ST_IDLE);
    assign br_ready_out = in_idle || (state_q == ST_SQUASH);
    assign accept       = br_valid_in && br_ready_out;

    // In IDLE the uop resolves straight off the ports; in WAIT_FLAGS from the latched copy.
    assign cur_kind = in_idle ? br_kind_e'(br_kind_in) : kind_q;
    assign cur_data = in_idle ? br_data_in : data_q;
    assign cur_pc   = in_idle ? br_pc_in : pc_q;
    assign cur_reg  = in_idle ? br_reg_val_in : reg_q;

    cond_eval u_cond_eval (
        .cond_i  (cond_e'(cur_data.condition)),
        .nzcv_i  (nzcv_in),
        .taken_o (cond_taken)
    );

    assign act_taken  = (cur_kind == BR_RET) || cond_taken;
    assign correct_pc = (cur_kind == BR_RET) ? cur_reg :
                        (act_taken ? cur_data.branch_target : cur_pc + 64'd4);
    assign mispredict = (cur_kind == BR_RET) ? (cur_reg != cur_data.branch_target) :
                        (act_taken != cur_data.predict_taken);
    assign delta      = correct_pc - cur_pc;
    assign delta_hi   = delta[63:OFF_W-1];
    assign fits       = (&delta_hi) || !(|delta_hi);

    always_comb begin
        resolve_go = 1'b0;
        if (in_idle) begin
            resolve_go = accept && (((cur_kind == BR_BCOND) && nzcv_valid_in) || (cur_kind == BR_RET));
        end else if (state_q == ST_WAIT_FLAGS) begin
            resolve_go = nzcv_valid_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_START;
            squash_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        squash_cnt_d = squash_cnt_q;
        case (state_q)
            ST_START: state_d = ST_IDLE;
            ST_IDLE, ST_WAIT_FLAGS: begin
                if (resolve_go) begin
                    if (!mispredict) begin
                        state_d = ST_IDLE;
                    end else if (fits) begin
                        state_d      = ST_SQUASH;
                        squash_cnt_d = SQUASH_INIT;
                    end else begin
                        state_d = ST_FAR;
                    end
                end else if (in_idle && accept && (cur_kind == BR_BCOND)) begin
                    state_d = ST_WAIT_FLAGS;
                end
            end
            ST_FAR: begin
                state_d      = ST_SQUASH;
                squash_cnt_d = SQUASH_INIT;
            end
            ST_SQUASH: begin
                squash_cnt_d = squash_cnt_q - 4'd1;
                if (squash_cnt_q == 4'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        start_d     = 1'b0;
        resolved_d  = 1'b0;
        incorrect_d = 1'b0;
        taken_d     = taken_q;
        xpc_d       = xpc_q;
        off_d       = off_q;
        if (state_q == ST_START) begin
            start_d = 1'b1;
            xpc_d   = START_PC;
            off_d   = '0;
        end else if (state_q == ST_FAR) begin
            incorrect_d = 1'b1;
            xpc_d       = fix_pc_q;
            off_d       = '0;
        end else if (resolve_go) begin
            if (cur_kind == BR_BCOND) begin
                resolved_d = 1'b1;
                taken_d    = act_taken;
                xpc_d      = cur_pc;
            end
            if (mispredict) begin
                xpc_d = cur_pc;
                if (fits) begin
                    incorrect_d = 1'b1;
                    off_d       = delta[OFF_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q     <= '0;
            reg_q    <= '0;
            kind_q   <= BR_BCOND;
            data_q   <= '0;
            fix_pc_q <= '0;
        end else begin
            if (in_idle && accept) begin
                pc_q   <= br_pc_in;
                reg_q  <= br_reg_val_in;
                kind_q <= br_kind_e'(br_kind_in);
                data_q <= br_data_in;
            end
            if (resolve_go) fix_pc_q <= correct_pc;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            start_q     <= 1'b0;
            resolved_q  <= 1'b0;
            taken_q     <= 1'b0;
            incorrect_q <= 1'b0;
            xpc_q       <= '0;
            off_q       <= '0;
        end else begin
            start_q     <= start_d;
            resolved_q  <= resolved_d;
            taken_q     <= taken_d;
            incorrect_q <= incorrect_d;
            xpc_q       <= xpc_d;
            off_q       <= off_d;
        end
    end

    assign start_signal        = start_q;
    assign x_bcond_resolved    = resolved_q;
    assign x_taken             = taken_q;
    assign x_pc_incorrect      = incorrect_q;
    assign x_pc                = xpc_q;
    assign x_correction_offset = off_q;

endmodule
